// File: rtl/seg_digit_monitor.sv
// Seven-segment bus monitor: debounces an active-low segment pattern, decodes it back to a
// hex digit and classifies each digit change as up, down or jump.
module seg_digit_monitor #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       sample_en,
    input  logic [7:0] seg,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       new_digit,
    output logic [1:0] dir,
    output logic       bad_pattern,
    output logic       dp_lit,
    output logic [7:0] up_count,
    output logic [7:0] down_count
);

    localparam logic [6:0] Blank     = 7'h7F;
    localparam logic [7:0] CntAccept = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CntHold   = 8'(STABLE_CYCLES);

    typedef enum logic {StEmpty, StLocked} state_e;

    state_e     state_q;
    logic [6:0] cand_q;
    logic [6:0] acc_q;
    logic [7:0] cnt_q;

    logic       glyph_ok;
    logic [3:0] glyph_code;
    logic [1:0] step_dir;

    assign digit_valid = (state_q == StLocked);

    always_comb begin
        glyph_ok   = 1'b1;
        glyph_code = 4'h0;
        unique case (cand_q)
            7'h40: glyph_code = 4'h0;
            7'h79: glyph_code = 4'h1;
            7'h24: glyph_code = 4'h2;
            7'h30: glyph_code = 4'h3;
            7'h19: glyph_code = 4'h4;
            7'h12: glyph_code = 4'h5;
            7'h02: glyph_code = 4'h6;
            7'h78: glyph_code = 4'h7;
            7'h00: glyph_code = 4'h8;
            7'h10: glyph_code = 4'h9;
            7'h08: glyph_code = 4'hA;
            7'h03: glyph_code = 4'hB;
            7'h46: glyph_code = 4'hC;
            7'h21: glyph_code = 4'hD;
            7'h06: glyph_code = 4'hE;
            7'h0E: glyph_code = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    // Direction is only meaningful relative to a previously locked digit.
    always_comb begin
        step_dir = 2'b11;
        if (state_q == StEmpty) begin
            step_dir = 2'b00;
        end else if (glyph_code == 4'(digit + 4'd1)) begin
            step_dir = 2'b01;
        end else if (glyph_code == 4'(digit - 4'd1)) begin
            step_dir = 2'b10;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= StEmpty;
            cand_q      <= Blank;
            acc_q       <= Blank;
            cnt_q       <= 8'd0;
            digit       <= 4'h0;
            new_digit   <= 1'b0;
            dir         <= 2'b00;
            bad_pattern <= 1'b0;
            dp_lit      <= 1'b0;
            up_count    <= 8'd0;
            down_count  <= 8'd0;
        end else begin
            new_digit   <= 1'b0;
            bad_pattern <= 1'b0;
            if (sample_en) begin
                dp_lit <= ~seg[7];
                if (seg[6:0] != cand_q) begin
                    cand_q <= seg[6:0];
                    cnt_q  <= 8'd1;
                end else if (cnt_q == CntAccept) begin
                    cnt_q <= CntHold;
                    // A glitch that settles back onto the stored pattern is ignored.
                    if (cand_q != acc_q) begin
                        acc_q <= cand_q;
                        if (glyph_ok) begin
                            state_q   <= StLocked;
                            digit     <= glyph_code;
                            new_digit <= 1'b1;
                            dir       <= step_dir;
                            if (step_dir == 2'b01 && up_count != 8'hFF) begin
                                up_count <= up_count + 8'd1;
                            end
                            if (step_dir == 2'b10 && down_count != 8'hFF) begin
                                down_count <= down_count + 8'd1;
                            end
                        end else begin
                            state_q     <= StEmpty;
                            dir         <= 2'b00;
                            bad_pattern <= (cand_q != Blank);
                        end
                    end
                end else if (cnt_q != CntHold) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

endmodule
